// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared definitions for the restoring divider: FSM state encoding and
//   the iteration-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width for a given operand width. One spare bit keeps
  // the count WIDTH-1 representable for any WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step
//   Combinational WIDTH+1-bit trial subtract: minuend - subtrahend, built as
//   minuend + ~subtrahend + 1 through a ripple chain of full-adder cells.
// Ports
//   minuend     in   WIDTH+1  shifted partial remainder {R, next Q bit}
//   subtrahend  in   WIDTH+1  zero-extended divisor
//   difference  out  WIDTH    low WIDTH bits of the difference
//   no_borrow   out  1        carry out of the chain; 1 when minuend >= subtrahend
module divider_step #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH:0]   subtrahend,
  output logic [WIDTH-1:0] difference,
  output logic             no_borrow
);

  logic [WIDTH:0]   sub_inv;
  logic [WIDTH+1:0] carry;

  assign sub_inv  = ~subtrahend;
  assign carry[0] = 1'b1;  // +1 completes the two's complement of the subtrahend

  // Carry chain spans all WIDTH+1 bits so the final carry is the borrow flag.
  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_carry
    assign carry[gi+1] = (minuend[gi] & sub_inv[gi]) |
                         (carry[gi] & (minuend[gi] ^ sub_inv[gi]));
  end

  // The difference MSB is only needed when there is no borrow, and then the
  // result is below the divisor, so it always fits in WIDTH bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign difference[gi] = minuend[gi] ^ sub_inv[gi] ^ carry[gi];
  end

  assign no_borrow = carry[WIDTH+1];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider
//   Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend divided by a
//   WIDTH-bit divisor, one quotient bit per clock, valid/ready on both sides.
//   Divide-by-zero and quotient-overflow are detected at accept time and
//   reported after a single cycle with quotient all ones and remainder 0.
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    operand handshake (accepted only in IDLE)
//   dividend, divisor      unsigned operands
//   out_valid / out_ready  result handshake; result held until accepted
//   quotient, remainder    unsigned result
//   div_by_zero, overflow  exception flags for the current result
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  // Partial remainder stays below the divisor, so WIDTH bits are enough.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] dividend_hi;
  logic [WIDTH-1:0] dividend_lo;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_step;

  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign dividend_lo = dividend[WIDTH-1:0];

  // Shift the next dividend bit (Q MSB) into the partial remainder.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .minuend    (trial),
    .subtrahend ({1'b0, dvs_reg}),
    .difference (diff),
    .no_borrow  (no_borrow)
  );

  // Restore (keep the trial value) when the subtraction borrows.
  assign r_next    = no_borrow ? diff : trial[WIDTH-1:0];
  assign q_next    = {q_reg[WIDTH-2:0], no_borrow};
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      r_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            dvs_reg  <= divisor;
            if (divisor == '0) begin
              state       <= ST_DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= '0;
            end else if (dividend_hi >= divisor) begin
              // Quotient would need more than WIDTH bits.
              state       <= ST_DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              state   <= ST_RUN;
              r_reg   <= dividend_hi;
              q_reg   <= dividend_lo;
              cnt_reg <= '0;
            end
          end
        end

        ST_RUN: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            state       <= ST_DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider
//   Self-checking bench for restoring_divider (WIDTH=3): directed table,
//   backpressure and reset-mid-run sequences, then every dividend/divisor
//   pair in random order against an arithmetic reference model.
module tb_restoring_divider;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int tests_run;
  int tests_failed;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dd;
    int ds;
    int q;
    int r;
    int dz;
    int ov;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the flag rules applied first.
  task automatic model(input int dd, input int ds, output int q, output int r,
                       output int dz, output int ov, output int lat);
    q = (1 << W) - 1; r = 0; dz = 0; ov = 0; lat = 0;
    if (ds == 0) dz = 1;
    else if (dd / (1 << W) >= ds) ov = 1;
    else begin
      q = dd / ds; r = dd % ds; lat = W;
    end
  endtask

  // Called at a negedge. Drives one operation with a 1-cycle in_valid pulse,
  // measures latency in rising edges after the accept edge, holds out_ready
  // low for 'hold' cycles (optionally with in_valid asserted to check it is
  // ignored), then accepts the result.
  task automatic do_op(input int dd, input int ds, input int hold, input bit poke,
                       output int q, output int r, output int dz, output int ov,
                       output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_op", int'(in_ready), 1);
    dividend = 6'(dd);
    divisor  = 3'(ds);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 6'($urandom);
    divisor  = 3'($urandom);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 50) begin
      chk("busy_in_ready", int'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    q  = int'(quotient);
    r  = int'(remainder);
    dz = int'(div_by_zero);
    ov = int'(overflow);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        dividend = 6'($urandom);
        divisor  = 3'($urandom);
        in_valid = 1'b1;
      end
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_quotient", int'(quotient), q);
      chk("hold_remainder", int'(remainder), r);
      chk("hold_flags", int'({div_by_zero, overflow}), dz * 2 + ov);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
  endtask

  vec_t vecs[6];
  int   order[512];

  initial begin
    int q, r, dz, ov, lat;
    int eq, er, edz, eov, elat;
    int tmp, j;

    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs[0] = '{dd: 23, ds: 5, q: 4, r: 3, dz: 0, ov: 0, lat: 3};
    vecs[1] = '{dd: 49, ds: 7, q: 7, r: 0, dz: 0, ov: 0, lat: 3};
    vecs[2] = '{dd: 0,  ds: 3, q: 0, r: 0, dz: 0, ov: 0, lat: 3};
    vecs[3] = '{dd: 7,  ds: 1, q: 7, r: 0, dz: 0, ov: 0, lat: 3};
    vecs[4] = '{dd: 56, ds: 7, q: 7, r: 0, dz: 0, ov: 1, lat: 0};
    vecs[5] = '{dd: 12, ds: 0, q: 7, r: 0, dz: 1, ov: 0, lat: 0};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_flags", int'({div_by_zero, overflow}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].dd, vecs[i].ds, 0, 1'b0, q, r, dz, ov, lat);
      $display("[TB] vec %0d: %0d/%0d -> q=%0d r=%0d dz=%0d ov=%0d lat=%0d",
               i, vecs[i].dd, vecs[i].ds, q, r, dz, ov, lat);
      chk("vec_quotient", q, vecs[i].q);
      chk("vec_remainder", r, vecs[i].r);
      chk("vec_div_by_zero", dz, vecs[i].dz);
      chk("vec_overflow", ov, vecs[i].ov);
      chk("vec_latency", lat, vecs[i].lat);
    end

    // Backpressure: result held for 5 cycles with in_valid poked meanwhile
    do_op(42, 6, 5, 1'b1, q, r, dz, ov, lat);
    $display("[TB] backpressure 42/6 -> q=%0d r=%0d", q, r);
    chk("bp_quotient", q, 7);
    chk("bp_remainder", r, 0);
    chk("bp_flags", dz * 2 + ov, 0);

    // Reset in the middle of RUN
    dividend = 6'd23;
    divisor  = 3'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", int'(in_ready), 1);
    chk("midrun_rst_out_valid", int'(out_valid), 0);
    chk("midrun_rst_outputs", int'({quotient, remainder, div_by_zero, overflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_out_valid", int'(out_valid), 0);
    end
    do_op(20, 3, 0, 1'b0, q, r, dz, ov, lat);
    $display("[TB] after reset 20/3 -> q=%0d r=%0d", q, r);
    chk("post_rst_quotient", q, 6);
    chk("post_rst_remainder", r, 2);

    // Every operand pair, shuffled
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      int dd, ds;
      dd = order[i] / 8;
      ds = order[i] % 8;
      do_op(dd, ds, int'($urandom_range(1, 0)), 1'b0, q, r, dz, ov, lat);
      model(dd, ds, eq, er, edz, eov, elat);
      $display("[TB] rnd %0d: %0d/%0d -> q=%0d r=%0d dz=%0d ov=%0d lat=%0d",
               i, dd, ds, q, r, dz, ov, lat);
      chk("rnd_quotient", q, eq);
      chk("rnd_remainder", r, er);
      chk("rnd_div_by_zero", dz, edz);
      chk("rnd_overflow", ov, eov);
      chk("rnd_latency", lat, elat);
      if (edz == 0 && eov == 0) begin
        chk("rnd_invariant", q * ds + r, dd);
        chk("rnd_rem_lt_div", int'(r < ds), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
